// File: rtl/receptor_serie32.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from a one-bit stream
// and holds each finished word on Q behind a VALID/ACK handshake.
module receptor_serie32 #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             CLR,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVR,
  output logic             BUSY,
  output logic [CW-1:0]    CNT
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dirl_q, dirl_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ins_dir_s;
  logic             done_s;
  logic [WIDTH-1:0] sh_ins_s;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dirl_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dirl_q  <= dirl_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: bit insertion, word completion, handshake and abort
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dirl_d  = dirl_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done_s  = 1'b0;

    // The first bit of a word uses the live DIR; later bits use the latched copy
    ins_dir_s = (state_q == IDLE) ? DIR : dirl_q;
    if (ins_dir_s) begin
      sh_ins_s = {sh_q[WIDTH-2:0], S_IN};
    end else begin
      sh_ins_s = {S_IN, sh_q[WIDTH-1:1]};
    end

    if (CLR) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      ovr_d   = 1'b0;
    end else if (ENB) begin
      case (state_q)
        IDLE: begin
          dirl_d  = DIR;
          sh_d    = sh_ins_s;
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
          state_d = RECV;
        end
        RECV: begin
          sh_d = sh_ins_s;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_s  = 1'b1;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A completion overwriting an unconsumed word is an overrun unless ACKed now
    if (done_s) begin
      q_d     = sh_ins_s;
      valid_d = 1'b1;
      if (valid_q && !ACK) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_d;
      end
    end else if (ACK && valid_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign OVR   = ovr_q;
  assign BUSY  = (state_q == RECV);
  assign CNT   = cnt_q;

endmodule

// File: tb/tb_receptor_serie32.sv
// Self-checking bench for receptor_serie32 using a queue of expected words.
module tb_receptor_serie32;
  localparam int W  = 32;
  localparam int CWB = 5;

  logic          CLK = 1'b0;
  logic          RST, ENB, DIR, S_IN, CLR, ACK;
  logic [W-1:0]  Q;
  logic          VALID, OVR, BUSY;
  logic [CWB-1:0] CNT;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  receptor_serie32 #(.WIDTH(W), .CW(CWB)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .DIR(DIR), .S_IN(S_IN),
    .CLR(CLR), .ACK(ACK), .Q(Q), .VALID(VALID), .OVR(OVR),
    .BUSY(BUSY), .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic a);
    ENB = 1'b1; S_IN = b; ACK = a;
    tick();
    ENB = 1'b0; ACK = 1'b0;
  endtask

  // Sends bits [from, to) of word in order dir; ack asserted on the last bit if ack_last
  task automatic send_range(input logic [W-1:0] w, input logic d, input int from, input int to, input logic ack_last);
    DIR = d;
    for (int i = from; i < to; i++) begin
      send_bit(d ? w[W-1-i] : w[i], ack_last && (i == W-1));
    end
  endtask

  task automatic do_ack();
    ACK = 1'b1; tick(); ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; ENB = 1'b0; DIR = 1'b0; S_IN = 1'b0; CLR = 1'b0; ACK = 1'b0;
    #12;
    n_checks++; if ({Q, VALID, OVR, BUSY, CNT} !== {32'h0, 1'b0, 1'b0, 1'b0, 5'd0})
      $display("FAIL reset_init Q=%h V=%b O=%b B=%b C=%0d", Q, VALID, OVR, BUSY, CNT); else n_pass++;
    RST = 1'b0;
    tick();
    send_range(32'h0000_0001, 1'b0, 0, W, 1'b0);
    send_range(32'h0000_0000, 1'b0, 0, 17, 1'b0);
    n_checks++; if (CNT !== 5'd17 || VALID !== 1'b1 || BUSY !== 1'b1)
      $display("FAIL pre_reset CNT=%0d V=%b B=%b want 17 1 1", CNT, VALID, BUSY); else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_checks++; if ({Q, VALID, OVR, BUSY, CNT} !== {32'h0, 1'b0, 1'b0, 1'b0, 5'd0})
      $display("FAIL async_reset Q=%h V=%b O=%b B=%b C=%0d", Q, VALID, OVR, BUSY, CNT); else n_pass++;
    #1 RST = 1'b0;
  endtask

  task automatic test_lsb_first();
    exp_q.push_back(32'hA5A5_0F0F);
    send_range(32'hA5A5_0F0F, 1'b0, 0, W-1, 1'b0);
    n_checks++; if (VALID !== 1'b0 || CNT !== 5'd31)
      $display("FAIL lsb_edge31 V=%b CNT=%0d want 0 31", VALID, CNT); else n_pass++;
    send_range(32'hA5A5_0F0F, 1'b0, W-1, W, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1 || CNT !== 5'd0 || BUSY !== 1'b0)
      $display("FAIL lsb_word Q=%h V=%b C=%0d B=%b want %h 1 0 0", Q, VALID, CNT, BUSY, e); else n_pass++;
    do_ack();
    n_checks++; if (VALID !== 1'b0)
      $display("FAIL lsb_ack VALID=%b want 0", VALID); else n_pass++;
  endtask

  task automatic test_msb_gated();
    logic [W-1:0] w;
    logic [CWB-1:0] held;
    int hold_bad;
    w = 32'h8000_0001;
    hold_bad = 0;
    exp_q.push_back(w);
    DIR = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == 10) DIR = 1'b0;
      send_bit(w[W-1-i], 1'b0);
      if (i != W-1) begin
        held = CNT;
        tick();
        if (CNT !== held) hold_bad++;
      end
    end
    n_checks++; if (hold_bad != 0)
      $display("FAIL msb_hold %0d hold cycles changed CNT, want 0", hold_bad); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1)
      $display("FAIL msb_word Q=%h V=%b want %h 1", Q, VALID, e); else n_pass++;
    do_ack();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hDEAD_BEEF);
    send_range(32'h1234_5678, 1'b0, 0, W, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1 || OVR !== 1'b0)
      $display("FAIL b2b_first Q=%h V=%b O=%b want %h 1 0", Q, VALID, OVR, e); else n_pass++;
    send_range(32'hDEAD_BEEF, 1'b0, 0, W, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1 || OVR !== 1'b1)
      $display("FAIL b2b_ovr Q=%h V=%b O=%b want %h 1 1", Q, VALID, OVR, e); else n_pass++;
    do_ack();
    CLR = 1'b1; tick(); CLR = 1'b0;
    n_checks++; if (OVR !== 1'b0 || VALID !== 1'b0)
      $display("FAIL clr_ovr OVR=%b V=%b want 0 0", OVR, VALID); else n_pass++;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hDEAD_BEEF);
    send_range(32'h1234_5678, 1'b0, 0, W, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1)
      $display("FAIL b2b_ack_first Q=%h V=%b want %h 1", Q, VALID, e); else n_pass++;
    send_range(32'hDEAD_BEEF, 1'b0, 0, W, 1'b1);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1 || OVR !== 1'b0)
      $display("FAIL b2b_ack Q=%h V=%b O=%b want %h 1 0", Q, VALID, OVR, e); else n_pass++;
  endtask

  task automatic test_clr();
    send_range(32'h5555_AAAA, 1'b1, 0, 20, 1'b0);
    ENB = 1'b1; CLR = 1'b1; S_IN = 1'b1;
    tick();
    ENB = 1'b0; CLR = 1'b0;
    n_checks++; if (CNT !== 5'd0 || BUSY !== 1'b0 || Q !== 32'hDEAD_BEEF || VALID !== 1'b1)
      $display("FAIL clr_abort C=%0d B=%b Q=%h V=%b want 0 0 deadbeef 1", CNT, BUSY, Q, VALID); else n_pass++;
    exp_q.push_back(32'h0000_FFFF);
    send_range(32'h0000_FFFF, 1'b0, 0, W, 1'b1);
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1 || OVR !== 1'b0)
      $display("FAIL clr_next Q=%h V=%b O=%b want %h 1 0", Q, VALID, OVR, e); else n_pass++;
    do_ack();
  endtask

  task automatic test_loopback();
    logic [W-1:0] sr;
    sr = 32'hC3C3_C3C3;
    exp_q.push_back(sr);
    DIR = 1'b1;
    for (int i = 0; i < W; i++) begin
      send_bit(sr[W-1], 1'b0);
      sr = {sr[W-2:0], 1'b0};
    end
    e = exp_q.pop_front();
    n_checks++; if (Q !== e || VALID !== 1'b1)
      $display("FAIL loopback Q=%h V=%b want %h 1", Q, VALID, e); else n_pass++;
    do_ack();
    n_checks++; if (VALID !== 1'b0 || Q !== e)
      $display("FAIL loopback_ack V=%b Q=%h want 0 %h", VALID, Q, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_gated();
    test_back_to_back();
    test_clr();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
